s2p_framer: RTL and testbench

//  Parametrised serial-to-parallel framer, successor to the fixed 8-stage S2P chain.
//  - Collects DEPTH words of W bits, arriving one per valid/ready beat, into one parallel frame.
//  - Output is double-buffered with a valid/ready handshake and backpressure.
//  - A flush emits a partial frame early; the number of valid words is reported.
//  - Sits between a serial sample source and wide parallel consumers (filters, packers).

---
 rtl/s2p_framer.sv | 105 ++++++++++
 tb/tb_s2p_framer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_framer.sv
// Serial-to-parallel framer: packs DEPTH words of W bits into one frame
// behind a double-buffered valid/ready output stage with early flush.
module s2p_framer #(
  parameter int W         = 16,
  parameter int DEPTH     = 8,
  parameter int FIRST_MSB = 1,
  localparam int CW       = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W*DEPTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int FW = W*DEPTH;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [FW-1:0] acc, acc_n, load_data;
  logic [CW-1:0] cnt, cnt_n, load_cnt, pos;
  logic [0:0]    state, state_n;
  logic          flush_pend, flush_pend_n;
  logic          hold_free, beat, full, load;

  assign hold_free = !out_valid | out_ready;
  assign in_ready  = rst_n & (state == FILL);
  assign beat      = in_valid & in_ready;
  assign busy      = (cnt != '0) | (state == PEND);
  assign pos       = (FIRST_MSB != 0) ? (CW'(DEPTH-1) - cnt) : cnt;

  always_comb begin
    acc_n        = acc;
    cnt_n        = cnt;
    state_n      = state;
    flush_pend_n = flush_pend;
    load         = 1'b0;
    load_data    = acc;
    load_cnt     = cnt;
    full         = 1'b0;
    unique case (state)
      FILL: begin
        if (beat) begin
          for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) == pos) acc_n[k*W +: W] = in_data;
          end
          cnt_n = cnt + CW'(1);
        end
        full = (cnt_n == CW'(DEPTH));
        // a full frame absorbs a same-cycle flush
        if (full || (flush && cnt_n != '0)) begin
          if (hold_free) begin
            load      = 1'b1;
            load_data = acc_n;
            load_cnt  = cnt_n;
            acc_n     = '0;
            cnt_n     = '0;
          end else begin
            state_n      = PEND;
            flush_pend_n = !full;
          end
        end
      end
      PEND: begin
        if (hold_free) begin
          load         = 1'b1;
          acc_n        = '0;
          cnt_n        = '0;
          state_n      = FILL;
          flush_pend_n = 1'b0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      state      <= FILL;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      state      <= state_n;
      flush_pend <= flush_pend_n;
      out_valid  <= load | (out_valid & !out_ready);
      if (load) begin
        out_data  <= load_data;
        out_count <= load_cnt;
      end
    end
  end

endmodule

// File: tb/tb_s2p_framer.sv
// Bench for s2p_framer: directed vector table, hand sequences,
// and random traffic against a queue-based frame model.
module tb_s2p_framer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_ready;
  logic        in_ready, in_ready0;
  logic        out_valid, out_valid0;
  logic [31:0] out_data, out_data0;
  logic [2:0]  out_count, out_count0;
  logic        busy, busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  s2p_framer #(.W(W), .DEPTH(DEPTH), .FIRST_MSB(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  s2p_framer #(.W(W), .DEPTH(DEPTH), .FIRST_MSB(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_count(out_count0), .busy(busy0)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] pack(input int q[$], input bit msb);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < q.size(); i++) begin
      b = 8'(q[i]);
      if (msb) r[(DEPTH-1-i)*8 +: 8] = b;
      else     r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  // Frame-level model: words queue into a frame, frames close on
  // fill or flush, and wait while the output slot is occupied.
  int mq[$];
  int hq[$];
  bit mpend, mhv;

  always @(posedge clk or negedge rst_n) begin
    bit hf, ld;
    if (!rst_n) begin
      mq.delete();
      hq.delete();
      mpend = 1'b0;
      mhv   = 1'b0;
    end else begin
      hf = !mhv || out_ready;
      ld = 1'b0;
      if (mpend) begin
        if (hf) begin
          hq = mq;
          mq.delete();
          mpend = 1'b0;
          ld = 1'b1;
        end
      end else begin
        if (in_valid) mq.push_back(int'(in_data));
        if (mq.size() == DEPTH || (flush && mq.size() > 0)) begin
          if (hf) begin
            hq = mq;
            mq.delete();
            ld = 1'b1;
          end else begin
            mpend = 1'b1;
          end
        end
      end
      mhv = ld || (mhv && !out_ready);
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", 64'(in_ready), 64'(rst_n && !mpend));
    chk("m_in_ready0", 64'(in_ready0), 64'(rst_n && !mpend));
    chk("m_out_valid", 64'(out_valid), 64'(mhv));
    chk("m_busy", 64'(busy), 64'(mq.size() != 0 || mpend));
    if (mhv) begin
      chk("m_data_msb", 64'(out_data), 64'(pack(hq, 1'b1)));
      chk("m_data_lsb", 64'(out_data0), 64'(pack(hq, 1'b0)));
      chk("m_count", 64'(out_count), 64'(hq.size()));
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_d1;
    logic [31:0] e_d0;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv[15];

  task automatic step(input logic v, input logic [7:0] d,
                      input logic fl, input logic ordy);
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  k;
    logic r;
    tv[0]  = '{1, 8'h01, 0, 1, 1, 0, 0, 0, 0};
    tv[1]  = '{1, 8'h02, 0, 1, 1, 0, 0, 0, 0};
    tv[2]  = '{1, 8'h03, 0, 1, 1, 0, 0, 0, 0};
    tv[3]  = '{1, 8'h04, 0, 1, 1, 1, 32'h01020304, 32'h04030201, 4};
    tv[4]  = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 0};
    tv[5]  = '{1, 8'hAA, 0, 1, 1, 0, 0, 0, 0};
    tv[6]  = '{1, 8'hBB, 0, 1, 1, 0, 0, 0, 0};
    tv[7]  = '{0, 8'h00, 1, 1, 1, 1, 32'hAABB0000, 32'h0000BBAA, 2};
    tv[8]  = '{0, 8'h00, 1, 1, 1, 0, 0, 0, 0};
    tv[9]  = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 0};
    tv[10] = '{1, 8'h01, 0, 1, 1, 0, 0, 0, 0};
    tv[11] = '{1, 8'h02, 0, 1, 1, 0, 0, 0, 0};
    tv[12] = '{1, 8'h03, 0, 1, 1, 0, 0, 0, 0};
    tv[13] = '{1, 8'h04, 1, 1, 1, 1, 32'h01020304, 32'h04030201, 4};
    tv[14] = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 0};

    rst_n = 1'b0;
    in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_count", 64'(out_count), 0);
    chk("rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 1);

    for (int i = 0; i < 15; i++) begin
      step(tv[i].v, tv[i].d, tv[i].fl, tv[i].ordy);
      chk($sformatf("tv%0d_in_ready", i), 64'(in_ready), 64'(tv[i].e_ir));
      chk($sformatf("tv%0d_out_valid", i), 64'(out_valid), 64'(tv[i].e_ov));
      chk($sformatf("tv%0d_out_valid0", i), 64'(out_valid0), 64'(tv[i].e_ov));
      if (tv[i].e_ov) begin
        chk($sformatf("tv%0d_data", i), 64'(out_data), 64'(tv[i].e_d1));
        chk($sformatf("tv%0d_data0", i), 64'(out_data0), 64'(tv[i].e_d0));
        chk($sformatf("tv%0d_count", i), 64'(out_count), 64'(tv[i].e_cnt));
      end
    end

    // backpressure: hold full plus a second full frame waiting
    out_ready = 0;
    flush = 0;
    k = 1;
    for (int n = 0; n < 40 && k <= 8; n++) begin
      in_valid = 1;
      in_data = 8'(k);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) k++;
    end
    in_valid = 0;
    chk("t3_words", 64'(k), 9);
    chk("t3_in_ready_low", 64'(in_ready), 0);
    chk("t3_frame1", 64'(out_data), 64'h01020304);
    repeat (2) step(0, 0, 0, 0);
    chk("t3_still_held", 64'(in_ready), 0);
    chk("t3_busy", 64'(busy), 1);
    step(0, 0, 0, 1);
    chk("t3_ov2", 64'(out_valid), 1);
    chk("t3_frame2", 64'(out_data), 64'h05060708);
    chk("t3_in_ready_back", 64'(in_ready), 1);
    step(0, 0, 0, 1);
    chk("t3_drained", 64'(out_valid), 0);

    // reset in the middle of a frame
    step(1, 8'h51, 0, 0);
    step(1, 8'h52, 0, 0);
    step(1, 8'h53, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready", 64'(in_ready), 0);
    chk("t6_out_data", 64'(out_data), 0);
    chk("t6_busy", 64'(busy), 0);
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", 64'(in_ready), 1);
    chk("t6_rel_ov", 64'(out_valid), 0);
    chk("t6_rel_count", 64'(out_count), 0);
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    step(1, 8'h44, 0, 1);
    chk("t6_ov", 64'(out_valid), 1);
    chk("t6_frame", 64'(out_data), 64'h11223344);
    chk("t6_count", 64'(out_count), 4);

    // random traffic; checked each cycle against the frame model
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) != 0));
    end
    step(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
